// File: rtl/conv_pe_scheduler_pkg.sv
// conv_sched_pkg: FSM states, PE mode codes and default geometry shared by the conv scheduler
package conv_sched_pkg;
    typedef enum logic [2:0] {IDLE, FEED, WAIT, CAPT, DONE} state_t;
    localparam logic [1:0] MODE_MAC  = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd1;
    localparam logic [1:0] MODE_IDLE = 2'd3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_IN_DIM = 4;
    localparam int DEF_K_DIM  = 3;
    localparam int DEF_PE_LAT = 1;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_pe_scheduler_if.sv
// conv_pe_scheduler_if: job handshake, operand selects, PE link and result bus of the scheduler
interface conv_pe_scheduler_if import conv_sched_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IN_DIM = DEF_IN_DIM,
    parameter int K_DIM  = DEF_K_DIM
);
    localparam int OUT_DIM = IN_DIM - K_DIM + 1;
    localparam int AW = cw(IN_DIM);
    localparam int KW = cw(K_DIM);
    logic start, abort, busy, done, pe_act;
    logic [AW-1:0] a_row, a_col;
    logic [KW-1:0] b_row, b_col;
    logic [1:0] pe_mode;
    logic [DATA_W-1:0] pe_result;
    logic [OUT_DIM*OUT_DIM*DATA_W-1:0] c_flat;
    logic [15:0] perf_cycles;
    modport master(
        input  start, abort, pe_result,
        output busy, done, a_row, a_col, b_row, b_col, pe_mode, pe_act, c_flat, perf_cycles
    );
    modport slave(
        output start, abort, pe_result,
        input  busy, done, a_row, a_col, b_row, b_col, pe_mode, pe_act, c_flat, perf_cycles
    );
endinterface

// File: rtl/conv_pe_scheduler_tap_counter.sv
// conv_tap_counter: nested tap (k_r,k_c) and window (out_r,out_c) counters with look-ahead values
module conv_tap_counter import conv_sched_pkg::*; #(
    parameter int K_DIM   = DEF_K_DIM,
    parameter int OUT_DIM = DEF_IN_DIM - DEF_K_DIM + 1,
    localparam int KW = cw(K_DIM),
    localparam int OW = cw(OUT_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_tap_en,
    input  logic          i_win_en,
    output logic [OW-1:0] o_out_r,
    output logic [OW-1:0] o_out_c,
    output logic [KW-1:0] o_nxt_k_r,
    output logic [KW-1:0] o_nxt_k_c,
    output logic [OW-1:0] o_nxt_out_r,
    output logic [OW-1:0] o_nxt_out_c,
    output logic          o_last_tap,
    output logic          o_last_win
);
    logic [KW-1:0] r_k_r, r_k_c;
    logic [OW-1:0] r_out_r, r_out_c;
    logic w_k_c_wrap, w_k_r_wrap, w_out_c_wrap, w_out_r_wrap;

    assign w_k_c_wrap   = r_k_c == KW'(K_DIM - 1);
    assign w_k_r_wrap   = r_k_r == KW'(K_DIM - 1);
    assign w_out_c_wrap = r_out_c == OW'(OUT_DIM - 1);
    assign w_out_r_wrap = r_out_r == OW'(OUT_DIM - 1);
    assign o_last_tap   = w_k_c_wrap && w_k_r_wrap;
    assign o_last_win   = w_out_c_wrap && w_out_r_wrap;
    assign o_out_r      = r_out_r;
    assign o_out_c      = r_out_c;

    // Next values are exported so the scheduler can register its outputs one cycle ahead
    always_comb begin
        o_nxt_k_c   = i_clr ? '0 : !i_tap_en ? r_k_c : w_k_c_wrap ? '0 : r_k_c + 1'b1;
        o_nxt_k_r   = i_clr ? '0 : !(i_tap_en && w_k_c_wrap) ? r_k_r : w_k_r_wrap ? '0 : r_k_r + 1'b1;
        o_nxt_out_c = i_clr ? '0 : !i_win_en ? r_out_c : w_out_c_wrap ? '0 : r_out_c + 1'b1;
        o_nxt_out_r = i_clr ? '0 : !(i_win_en && w_out_c_wrap) ? r_out_r : w_out_r_wrap ? '0 : r_out_r + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k_r   <= '0;
            r_k_c   <= '0;
            r_out_r <= '0;
            r_out_c <= '0;
        end else begin
            r_k_r   <= o_nxt_k_r;
            r_k_c   <= o_nxt_k_c;
            r_out_r <= o_nxt_out_r;
            r_out_c <= o_nxt_out_c;
        end
    end
endmodule

// File: rtl/conv_pe_scheduler.sv
// conv_pe_scheduler: sequences a 2x2 valid convolution through one shared MAC PE.
// Define SCHED_PERF_CNT_EN to build the saturating busy-cycle counter on perf_cycles.
module conv_pe_scheduler import conv_sched_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IN_DIM = DEF_IN_DIM,
    parameter int K_DIM  = DEF_K_DIM,
    parameter int PE_LAT = DEF_PE_LAT
) (
    input logic clk,
    input logic rst,
    conv_pe_scheduler_if.master bus
);
    localparam int OUT_DIM = IN_DIM - K_DIM + 1;
    localparam int AW = cw(IN_DIM);
    localparam int KW = cw(K_DIM);
    localparam int OW = cw(OUT_DIM);
    localparam int WW = cw(PE_LAT);

    state_t r_state, w_next;
    logic [WW-1:0] r_wait;
    logic r_busy, r_done, r_act;
    logic [1:0] r_mode, w_mode;
    logic [AW-1:0] r_a_row, r_a_col, w_a_row, w_a_col;
    logic [KW-1:0] r_b_row, r_b_col, w_b_row, w_b_col;
    logic [OUT_DIM*OUT_DIM*DATA_W-1:0] r_c;
    logic [OW-1:0] w_out_r, w_out_c, w_nxt_out_r, w_nxt_out_c;
    logic [KW-1:0] w_nxt_k_r, w_nxt_k_c;
    logic w_last_tap, w_last_win, w_feed;
    int w_idx;

    conv_tap_counter #(.K_DIM(K_DIM), .OUT_DIM(OUT_DIM)) u_cnt (
        .clk(clk),
        .rst(rst),
        .i_clr(r_state == IDLE),
        .i_tap_en(r_state == FEED),
        .i_win_en(r_state == CAPT),
        .o_out_r(w_out_r),
        .o_out_c(w_out_c),
        .o_nxt_k_r(w_nxt_k_r),
        .o_nxt_k_c(w_nxt_k_c),
        .o_nxt_out_r(w_nxt_out_r),
        .o_nxt_out_c(w_nxt_out_c),
        .o_last_tap(w_last_tap),
        .o_last_win(w_last_win)
    );

    assign w_idx = int'(w_out_r) * OUT_DIM + int'(w_out_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Outputs are computed from the next state so the registered copies line up with it
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = bus.start ? FEED : IDLE;
            FEED:    w_next = w_last_tap ? WAIT : FEED;
            WAIT:    w_next = (r_wait == WW'(PE_LAT - 1)) ? CAPT : WAIT;
            CAPT:    w_next = w_last_win ? DONE : FEED;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.abort && r_state != IDLE) w_next = IDLE;
        w_feed  = w_next == FEED;
        w_mode  = !w_feed ? MODE_IDLE : (w_nxt_k_r == '0 && w_nxt_k_c == '0) ? MODE_LOAD : MODE_MAC;
        w_a_row = w_feed ? AW'(w_nxt_out_r) + AW'(w_nxt_k_r) : '0;
        w_a_col = w_feed ? AW'(w_nxt_out_c) + AW'(w_nxt_k_c) : '0;
        w_b_row = w_feed ? KW'(K_DIM - 1) - w_nxt_k_r : '0;
        w_b_col = w_feed ? KW'(K_DIM - 1) - w_nxt_k_c : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_act   <= 1'b0;
            r_mode  <= '0;
            r_a_row <= '0;
            r_a_col <= '0;
            r_b_row <= '0;
            r_b_col <= '0;
            r_c     <= '0;
        end else begin
            r_wait  <= (r_state == WAIT) ? r_wait + 1'b1 : '0;
            r_busy  <= w_next != IDLE;
            r_done  <= w_next == DONE;
            r_act   <= w_feed;
            r_mode  <= w_mode;
            r_a_row <= w_a_row;
            r_a_col <= w_a_col;
            r_b_row <= w_b_row;
            r_b_col <= w_b_col;
            if (r_state == CAPT) r_c[w_idx*DATA_W +: DATA_W] <= bus.pe_result;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.pe_act  = r_act;
    assign bus.pe_mode = r_mode;
    assign bus.a_row   = r_a_row;
    assign bus.a_col   = r_a_col;
    assign bus.b_row   = r_b_row;
    assign bus.b_col   = r_b_col;
    assign bus.c_flat  = r_c;

`ifdef SCHED_PERF_CNT_EN
    logic [15:0] r_perf;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              r_perf <= '0;
        else if (r_busy && r_perf != 16'hFFFF) r_perf <= r_perf + 16'd1;
    end
    assign bus.perf_cycles = r_perf;
`else
    assign bus.perf_cycles = '0;
`endif
endmodule

// File: doc/conv_pe_scheduler.md
Name: conv_pe_scheduler

Overview:
- Controller that sequences one 2x2 valid convolution (4x4 activation window, 3x3 filter) through a single shared MAC processing element (`pe`).
- Each output word takes 9 MAC issue cycles, then a drain/capture phase.
- Drives operand-select indices and the PE mode, captures the PE result into output registers, and signals completion with a start/busy/done handshake.
- Sits between the layer-level controller and the operand muxes feeding `u_pe`.

Parameters:
- DATA_W, 8, operand/result width
- IN_DIM, 4, activation window side
- K_DIM, 3, filter side; OUT_DIM = IN_DIM-K_DIM+1 (derived, 2)
- PE_LAT, 1, cycles from operand issue to PE accumulator update being visible on pe_result

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- abort  in  1  synchronous cancel of a running job
- busy  out  1  high from the cycle after start is accepted until DONE ends
- done  out  1  single-cycle completion pulse
- a_row, a_col  out  $clog2(IN_DIM) each  activation element select (0-based)
- b_row, b_col  out  $clog2(K_DIM) each  filter element select (0-based)
- pe_mode  out  2  PE operation code (package constants)
- pe_act  out  1  operand valid to PE
- pe_result  in  DATA_W  PE accumulator output
- c_flat  out  OUT_DIM*OUT_DIM*DATA_W  results, word index r*OUT_DIM+c, LSB word = c11
- perf_cycles  out  16  busy-cycle count (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE -> FEED on start.
  - FEED issues K_DIM*K_DIM taps, one per cycle -> WAIT.
  - WAIT holds PE_LAT cycles -> CAPT.
  - CAPT lasts 1 cycle: loads pe_result into c_flat word (out_r,out_c). Goes to FEED if windows remain, otherwise to DONE.
  - DONE lasts 1 cycle with done=1 -> IDLE.
- Counters:
  - out_r and out_c (window position); k_r and k_c (tap position).
  - k_c wraps to 0 at K_DIM-1 and increments k_r.
  - Windows are ordered row-major: c11, c12, c21, c22.
- Index generation in FEED:
  - a_row = out_r+k_r; a_col = out_c+k_c.
  - b_row = K_DIM-1-k_r; b_col = K_DIM-1-k_c (filter flipped; first tap pairs a11 with b33).
- pe_act = 1 only in FEED.
- pe_mode:
  - MODE_LOAD on tap (0,0): product replaces the accumulator.
  - MODE_MAC on the other taps.
  - MODE_IDLE outside FEED.
- Arithmetic is entirely inside the PE; the scheduler does no arithmetic on data.
- Outputs a/b indices, pe_mode and pe_act are registered (Moore); index outputs are 0 outside FEED.
- Latency with defaults: start accepted at edge E0.
  - Window n occupies cycles 11n+1..11n+11.
  - done is high in cycle 45; busy is high for cycles 1..45.
- c_flat words update only in CAPT. They hold their value until overwritten by a later job.
- start while busy: ignored. start in the DONE cycle: ignored.
- abort while busy:
  - Next state IDLE; no done pulse; pe_mode = MODE_IDLE.
  - Words not yet captured keep their previous values.
- abort and CAPT in the same cycle: the capture still occurs.
- abort in IDLE: no effect.
- rst asserted mid-job: immediate return to reset values, including c_flat.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- Defined:
  - perf_cycles increments every busy cycle and saturates at 16'hFFFF.
  - It is not cleared by start; it is cleared only by rst.
- Undefined: perf_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Package conv_sched_pkg holds:
  - state enum (IDLE, FEED, WAIT, CAPT, DONE);
  - MODE_MAC=2'd0, MODE_LOAD=2'd1, MODE_IDLE=2'd3;
  - default DATA_W, IN_DIM and K_DIM constants.
- One natural sub-module, conv_tap_counter: the nested k_c/k_r and out_c/out_r counters with wrap and last-tap/last-window flags.

Test Plan:
- Use a behavioral PE model with LOAD/MAC and 1-cycle latency.
- All a=1, all b=1, pulse start -> c11=c12=c21=c22=9; done in cycle 45; busy for 45 cycles.
- a(r,c)=4(r-1)+c (1..16); b22=1, other b=0 -> c11=6, c12=7, c21=10, c22=11.
- Trace the first FEED window -> index sequence (a,b) = (11,33),(12,32),(13,31),(21,23),...,(33,11). pe_mode is LOAD only on the first tap.
- Assert abort in cycle 20 (during window c12) -> IDLE next cycle, no done. c11 holds the new value; c12/c21/c22 keep the prior job's values.
- Pulse start at cycle 10 of a running job, and drive rst low at cycle 30 -> second start is ignored. After reset all outputs are 0 and state is IDLE.
- With SCHED_PERF_CNT_EN, run two back-to-back jobs -> perf_cycles=90. Without the macro -> perf_cycles=0 throughout.
